four_serial_subtractor: RTL and testbench



---
 rtl/four_serial_subtractor.sv | 120 ++++++++++++
 tb/tb_four_serial_subtractor.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/four_serial_subtractor.sv
// Bit-serial ripple-borrow subtractor.
// One full-subtractor cell with a registered borrow computes a - b - b_zero,
// LSB first, over WIDTH clocks. start/busy/done handshake; results registered.
module four_serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_zero,
    output logic [WIDTH-1:0] diff,
    output logic             b_four,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;      // minuend, shifted right each bit
    logic [WIDTH-1:0] b_q, b_d;      // subtrahend, shifted right each bit
    logic [WIDTH-1:0] dsh_q, dsh_d;  // partial difference, filled from the MSB side
    logic             br_q, br_d;    // running borrow
    logic [CW-1:0]    cnt_q, cnt_d;  // index of the bit processed on the next edge
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bf_q, bf_d;
    logic             done_q, done_d;

    logic             ai, bi, d_bit, br_nxt;

    // Full-subtractor cell on the current LSB of the operand shifters.
    always_comb begin
        ai     = a_q[0];
        bi     = b_q[0];
        d_bit  = ai ^ bi ^ br_q;
        br_nxt = (~ai & bi) | (~(ai ^ bi) & br_q);
    end

    // Next-state and datapath update: accept in IDLE, one bit per edge in RUN.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        dsh_d   = dsh_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bf_d    = bf_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = b_zero;
                    dsh_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                dsh_d = {d_bit, dsh_q[WIDTH-1:1]};
                br_d  = br_nxt;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    // Last bit: publish the whole difference and final borrow at once
                    // so the outputs never show a partial result.
                    diff_d  = {d_bit, dsh_q[WIDTH-1:1]};
                    bf_d    = br_nxt;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            dsh_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bf_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            dsh_q   <= dsh_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bf_q    <= bf_d;
            done_q  <= done_d;
        end
    end

    assign diff   = diff_q;
    assign b_four = bf_q;
    assign busy   = (state_q == RUN);
    assign done   = done_q;

endmodule

// File: tb/tb_four_serial_subtractor.sv
// Scoreboard bench for four_serial_subtractor: a handshake model predicts
// busy/done each cycle, expected results are queued on accept and popped on done.
module tb_four_serial_subtractor;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             b_zero = 1'b0;
    logic [WIDTH-1:0] diff;
    logic             b_four;
    logic             busy;
    logic             done;

    four_serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .b_zero (b_zero),
        .diff   (diff),
        .b_four (b_four),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference handshake model and scoreboard.
    logic [WIDTH:0] sb_q[$];
    int             mcnt  = 0;
    bit             mdone = 1'b0;
    logic [WIDTH:0] last  = '0;
    int             ndone = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcnt  = 0;
            mdone = 1'b0;
            last  = '0;
            sb_q.delete();
        end else begin
            mdone = 1'b0;
            if (mcnt == 0) begin
                if (start) begin
                    sb_q.push_back(({1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, b_zero}));
                    mcnt = WIDTH;
                end
            end else begin
                mcnt = mcnt - 1;
                if (mcnt == 0) mdone = 1'b1;
            end
        end
    end

    // Check every cycle away from the active edge.
    always @(negedge clk) begin
        logic [WIDTH:0] e;
        chk("busy", 32'(busy), 32'(mcnt != 0));
        chk("done", 32'(done), 32'(mdone));
        chk("busy_done_excl", 32'(busy & done), 32'd0);
        if (mdone) begin
            ndone++;
            if (sb_q.size() == 0) begin
                chk("sb_empty", 32'd0, 32'd1);
            end else begin
                e = sb_q.pop_front();
                chk("result", 32'({b_four, diff}), 32'(e));
                last = e;
            end
        end
        chk("hold", 32'({b_four, diff}), 32'(last));
    end

    // Pulse start for one cycle, then wait until the done cycle.
    task automatic op(input logic [WIDTH-1:0] ai, input logic [WIDTH-1:0] bi, input logic bz);
        start  = 1'b1;
        a      = ai;
        b      = bi;
        b_zero = bz;
        @(negedge clk);
        start = 1'b0;
        a     = $urandom_range(0, 15);
        b     = $urandom_range(0, 15);
        repeat (WIDTH) @(negedge clk);
    endtask

    int d0;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_diff", 32'({b_four, diff}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed arithmetic cases
        op(4'd9, 4'd3, 1'b0);   chk("t_9_3",    32'({b_four, diff}), 32'd6);
        op(4'd3, 4'd9, 1'b0);   chk("t_3_9",    32'({b_four, diff}), 32'd26);
        op(4'd0, 4'd0, 1'b1);   chk("t_0_0_1",  32'({b_four, diff}), 32'd31);
        op(4'd15, 4'd15, 1'b0); chk("t_15_15",  32'({b_four, diff}), 32'd0);
        op(4'd15, 4'd0, 1'b1);  chk("t_15_0_1", 32'({b_four, diff}), 32'd14);
        repeat (2) @(negedge clk);

        // start during RUN is ignored
        start = 1'b1; a = 4'd9; b = 4'd3; b_zero = 1'b0;
        @(negedge clk); start = 1'b0;
        @(negedge clk); start = 1'b1; a = 4'd1; b = 4'd2;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        chk("ignore_done", 32'(done), 32'd1);
        chk("ignore_res", 32'({b_four, diff}), 32'd6);
        repeat (2) @(negedge clk);

        // start held high: back-to-back accepts, done every WIDTH+1 cycles
        d0 = ndone;
        start = 1'b1; a = 4'd5; b = 4'd7; b_zero = 1'b0;
        repeat (2 * (WIDTH + 1)) @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("held_count", 32'(ndone - d0), 32'd2);
        chk("held_res", 32'({b_four, diff}), 32'd30);
        repeat (2) @(negedge clk);

        // Reset mid-operation aborts with no done pulse
        d0 = ndone;
        start = 1'b1; a = 4'd9; b = 4'd3; b_zero = 1'b0;
        @(negedge clk); start = 1'b0;
        @(posedge clk); #2 rst_n = 1'b0;
        repeat (WIDTH + 2) @(negedge clk);
        chk("abort_out", 32'({b_four, diff}), 32'd0);
        chk("abort_nodone", 32'(ndone - d0), 32'd0);
        rst_n = 1'b1;
        op(4'd8, 4'd1, 1'b0);   chk("t_8_1", 32'({b_four, diff}), 32'd7);

        // Full sweep, back-to-back
        for (int bz = 0; bz < 2; bz++)
            for (int ia = 0; ia < 16; ia++)
                for (int ib = 0; ib < 16; ib++)
                    op(4'(ia), 4'(ib), 1'(bz));

        repeat (3) @(negedge clk);
        chk("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
